fifo_rd_ptr_empty: RTL and testbench
====================================

Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and flag controller for the DIF's dual-clock data FIFO. It sits directly downstream of the write-domain binary-to-Gray pointer stage: it takes the write pointer as Gray code, synchronises it into the read clock domain, and converts it back to binary. It then maintains the read pointer and produces the RAM read address, the Gray read pointer returned to the write side, and the empty, almost-empty, fill-level and underflow indications.

Parameters:
PTR_W, 8, pointer width; the FIFO address is PTR_W-1 bits and the top bit is the wrap bit (depth 128).
AE_TH, 4, almost-empty threshold; Out_Almost_Empty is 1 when the fill level is less than or equal to AE_TH.

Ports:
Clk  in  1  read-domain clock; all state changes on its rising edge.
Rst_N  in  1  asynchronous, active-low reset.
In_Wr_Gray  in  PTR_W  write pointer in Gray code, registered in the write domain.
Rd_En  in  1  read request.
Out_Rd_Addr  out  PTR_W-1  RAM read address (Rd_Bin[PTR_W-2:0]).
Out_Rd_Gray  out  PTR_W  registered Gray read pointer, sent to the write domain.
Out_Empty  out  1  registered empty flag.
Out_Almost_Empty  out  1  registered; 1 when the fill level is at or below AE_TH.
Out_Rd_Count  out  PTR_W  registered fill level (0..128).
Out_Underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (Rst_N=0, asynchronous) clears all registers to 0, except Out_Empty=1 and Out_Almost_Empty=1. Out_Underflow=0. Reset takes effect immediately, including in the middle of an operation.
- Synchroniser: Wr_Gray_S1 <= In_Wr_Gray; Wr_Gray_S2 <= Wr_Gray_S1.
  - No logic is placed between In_Wr_Gray and S1.
  - Latency from In_Wr_Gray to S2 is 2 edges.
- Wr_Bin_S2 is the combinational Gray-to-binary conversion of S2:
  - bit[PTR_W-1] = g[PTR_W-1];
  - bit[i] = bit[i+1] ^ g[i], down to bit 0.
- Read advance: Rd_Inc = Rd_En & ~Out_Empty.
  - Rd_Bin_Nxt = Rd_Bin + Rd_Inc, modulo 2^PTR_W (255 wraps to 0).
  - Rd_Gray_Nxt = Rd_Bin_Nxt ^ (Rd_Bin_Nxt >> 1).
  - Both are registered every edge.
- Empty: Out_Empty <= (Rd_Gray_Nxt == Wr_Gray_S2). The comparison uses the next read pointer, so a read of the last word raises Empty on the same edge that advances the pointer.
  - Empty falls on the 3rd rising edge after In_Wr_Gray changes (2 synchroniser edges plus 1 flag register edge).
- Fill level: Out_Rd_Count <= (Wr_Bin_S2 - Rd_Bin_Nxt), modulo 2^PTR_W.
- Almost empty: Out_Almost_Empty <= (that same difference <= AE_TH).
- Underflow: if Rd_En=1 while Out_Empty=1:
  - the pointer is held;
  - Out_Underflow=1 for exactly one cycle after the edge;
  - a held Rd_En gives one pulse per cycle.
- Simultaneous events: a write-pointer change and a read in the same cycle are independent.
  - Empty is evaluated against the S2 value current at that edge.
  - Because the synchroniser lags, Empty is pessimistic (may read empty when data exists), never optimistic.
- Wrap: when Rd_Bin goes from 255 to 0, Out_Rd_Gray goes from 0x80 to 0x00. The count arithmetic is modulo 256 and stays correct across the wrap.

Decomposition:
- Shared package fifo_pkg holds:
  - constants PTR_W=8 and ADDR_W=PTR_W-1;
  - the bin-to-gray and gray-to-bin functions, shared with the write-side pointer logic.
- One natural sub-module: gray_2_bin, a combinational PTR_W-bit converter instanced on Wr_Gray_S2.
- The synchroniser stays inline, with its two registers kept together for the timing constraints.

Test Plan:
1. Reset, then In_Wr_Gray=0x00 held -> Out_Empty=1, Out_Almost_Empty=1, Out_Rd_Count=0, Out_Rd_Gray=0x00, Out_Rd_Addr=0x00.
2. After reset, drive In_Wr_Gray=0x01 (binary 1) -> Out_Empty=0 and Out_Rd_Count=1 on the 3rd edge. Then Rd_En=1 for one cycle -> Out_Rd_Addr=0x01, Out_Rd_Gray=0x01, Out_Empty=1, Out_Rd_Count=0 on that edge.
3. Out_Empty=1, Rd_En=1 for 2 cycles -> Out_Underflow=1 for 2 cycles, Out_Rd_Addr unchanged, Out_Rd_Gray unchanged.
4. Read pointer at binary 255 (Out_Rd_Gray=0x80), In_Wr_Gray=0x00 (binary 0) -> Out_Rd_Count=1, Out_Empty=0. One read -> Out_Rd_Gray=0x00, Out_Rd_Addr=0x00, Out_Empty=1.
5. Fill level 5 (In_Wr_Gray=0x07, read pointer 0), AE_TH=4 -> Out_Almost_Empty=0. One read -> Out_Rd_Count=4, Out_Almost_Empty=1.
6. Fill level 5 mid-operation, pull Rst_N low between clock edges -> immediately Out_Empty=1, Out_Rd_Count=0, Out_Rd_Gray=0x00, Out_Underflow=0. After release -> Empty falls 3 edges later.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock data FIFO pointer logic.
//
// Contents:
//   PTR_W      pointer width; the top bit is the wrap bit
//   ADDR_W     RAM address width (PTR_W-1)
//   bin2gray   binary -> Gray conversion, PTR_W bits
//   gray2bin   Gray -> binary conversion, PTR_W bits
//
// The write-side pointer stage and the read-side controller both use these
// helpers, so both clock domains agree on the encoding.

package fifo_pkg;

    localparam int unsigned PTR_W  = 8;
    localparam int unsigned ADDR_W = PTR_W - 1;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
        logic [PTR_W-1:0] bin;
        bin[PTR_W-1] = gray[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_2_bin.sv
// Combinational Gray-to-binary converter.
//
// Ports:
//   gray  in   W  Gray-coded value
//   bin   out  W  binary equivalent
//
// Purely combinational; used on the synchronised write pointer.

module gray_2_bin #(
    parameter int unsigned W = fifo_pkg::PTR_W
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin        = '0;
        bin[W-1]   = gray[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and flag controller for the dual-clock data FIFO.
//
// Takes the Gray write pointer from the write domain, synchronises it with a
// two-flop chain, converts it back to binary and derives the read-side state.
//
// Ports:
//   Clk               in   1        read-domain clock
//   Rst_N             in   1        asynchronous active-low reset
//   In_Wr_Gray        in   PTR_W    Gray write pointer (write-domain register)
//   Rd_En             in   1        read request
//   Out_Rd_Addr       out  PTR_W-1  RAM read address
//   Out_Rd_Gray       out  PTR_W    registered Gray read pointer to write side
//   Out_Empty         out  1        registered empty flag
//   Out_Almost_Empty  out  1        registered, fill level <= AE_TH
//   Out_Rd_Count      out  PTR_W    registered fill level
//   Out_Underflow     out  1        one-cycle pulse per rejected read
//
// PTR_W must match fifo_pkg::PTR_W since the shared Gray helper is fixed-width.

module fifo_rd_ptr_empty #(
    parameter int unsigned PTR_W = fifo_pkg::PTR_W,
    parameter int unsigned AE_TH = 4
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic [PTR_W-1:0] In_Wr_Gray,
    input  logic             Rd_En,
    output logic [PTR_W-2:0] Out_Rd_Addr,
    output logic [PTR_W-1:0] Out_Rd_Gray,
    output logic             Out_Empty,
    output logic             Out_Almost_Empty,
    output logic [PTR_W-1:0] Out_Rd_Count,
    output logic             Out_Underflow
);

    import fifo_pkg::*;

    localparam logic [PTR_W-1:0] AeThresh = PTR_W'(AE_TH);

    // Synchroniser: kept as an adjacent pair with nothing in front of the
    // first stage so the CDC constraints can target it directly.
    logic [PTR_W-1:0] wr_gray_s1;
    logic [PTR_W-1:0] wr_gray_s2;

    logic [PTR_W-1:0] wr_bin_s2;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] rd_bin_nxt;
    logic [PTR_W-1:0] rd_gray_nxt;
    logic [PTR_W-1:0] fill_nxt;
    logic             rd_inc;
    logic             rd_reject;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            wr_gray_s1 <= '0;
            wr_gray_s2 <= '0;
        end else begin
            wr_gray_s1 <= In_Wr_Gray;
            wr_gray_s2 <= wr_gray_s1;
        end
    end

    gray_2_bin #(
        .W (PTR_W)
    ) u_wr_gray_2_bin (
        .gray (wr_gray_s2),
        .bin  (wr_bin_s2)
    );

    always_comb begin
        rd_inc      = Rd_En & ~Out_Empty;
        rd_reject   = Rd_En & Out_Empty;
        // Wraps modulo 2^PTR_W naturally.
        rd_bin_nxt  = rd_bin + {{(PTR_W-1){1'b0}}, rd_inc};
        rd_gray_nxt = bin2gray(rd_bin_nxt);
        // Modulo difference stays correct across the pointer wrap.
        fill_nxt    = wr_bin_s2 - rd_bin_nxt;
    end

    // Empty is judged against the post-read pointer so reading the last word
    // raises the flag on the same edge. The lagging S2 value can only make
    // the flag pessimistic.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            rd_bin           <= '0;
            Out_Rd_Gray      <= '0;
            Out_Empty        <= 1'b1;
            Out_Almost_Empty <= 1'b1;
            Out_Rd_Count     <= '0;
            Out_Underflow    <= 1'b0;
        end else begin
            rd_bin           <= rd_bin_nxt;
            Out_Rd_Gray      <= rd_gray_nxt;
            Out_Empty        <= (rd_gray_nxt == wr_gray_s2);
            Out_Almost_Empty <= (fill_nxt <= AeThresh);
            Out_Rd_Count     <= fill_nxt;
            Out_Underflow    <= rd_reject;
        end
    end

    assign Out_Rd_Addr = rd_bin[PTR_W-2:0];

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
module tb_fifo_rd_ptr_empty;

    logic       Clk;
    logic       Rst_N;
    logic [7:0] In_Wr_Gray;
    logic       Rd_En;
    logic [6:0] Out_Rd_Addr;
    logic [7:0] Out_Rd_Gray;
    logic       Out_Empty;
    logic       Out_Almost_Empty;
    logic [7:0] Out_Rd_Count;
    logic       Out_Underflow;

    fifo_rd_ptr_empty #(
        .PTR_W (8),
        .AE_TH (4)
    ) dut (
        .Clk              (Clk),
        .Rst_N            (Rst_N),
        .In_Wr_Gray       (In_Wr_Gray),
        .Rd_En            (Rd_En),
        .Out_Rd_Addr      (Out_Rd_Addr),
        .Out_Rd_Gray      (Out_Rd_Gray),
        .Out_Empty        (Out_Empty),
        .Out_Almost_Empty (Out_Almost_Empty),
        .Out_Rd_Count     (Out_Rd_Count),
        .Out_Underflow    (Out_Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        string      name;
        logic       empty;
        logic       ae;
        logic [7:0] count;
        logic [7:0] gray;
        logic [6:0] addr;
        logic       uf;
    } exp_t;

    exp_t sb_q[$];
    exp_t keep_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Expected output state after the edge that brings cyc to now+ofs.
    task automatic expect_at(input int ofs, input string name, input logic e, input logic ae,
                             input logic [7:0] cnt, input logic [7:0] gray,
                             input logic [6:0] addr, input logic uf);
        exp_t x;
        x.cyc   = cyc + ofs;
        x.name  = name;
        x.empty = e;
        x.ae    = ae;
        x.count = cnt;
        x.gray  = gray;
        x.addr  = addr;
        x.uf    = uf;
        sb_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Monitor: samples mid-cycle and retires every expectation due now.
    always @(negedge Clk) begin
        keep_q = {};
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) begin
                total++;
                if (Out_Empty !== sb_q[i].empty || Out_Almost_Empty !== sb_q[i].ae ||
                    Out_Rd_Count !== sb_q[i].count || Out_Rd_Gray !== sb_q[i].gray ||
                    Out_Rd_Addr !== sb_q[i].addr || Out_Underflow !== sb_q[i].uf) begin
                    bad++;
                    $display("FAIL %s: got empty=%b ae=%b cnt=%0d gray=%h addr=%h uf=%b, want empty=%b ae=%b cnt=%0d gray=%h addr=%h uf=%b",
                             sb_q[i].name, Out_Empty, Out_Almost_Empty, Out_Rd_Count,
                             Out_Rd_Gray, Out_Rd_Addr, Out_Underflow, sb_q[i].empty,
                             sb_q[i].ae, sb_q[i].count, sb_q[i].gray, sb_q[i].addr,
                             sb_q[i].uf);
                end
            end else if (sb_q[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: got no sample at cycle %0d, want one", sb_q[i].name,
                         sb_q[i].cyc);
            end else begin
                keep_q.push_back(sb_q[i]);
            end
        end
        sb_q = keep_q;
    end

    initial begin
        int n;
        Rst_N      = 1'b0;
        In_Wr_Gray = 8'h00;
        Rd_En      = 1'b0;
        step(2);
        Rst_N = 1'b1;

        // Reset state, idle with write pointer 0.
        expect_at(0, "rst_state", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(1, "idle_state", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        step(2);

        // One word arrives: empty falls on the 3rd edge.
        In_Wr_Gray = 8'h01;
        expect_at(1, "sync_lag1", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(2, "sync_lag2", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(3, "empty_fall", 0, 1, 8'd1, 8'h00, 7'h00, 0);
        step(3);

        // Read the last word, then keep reading while empty.
        Rd_En = 1'b1;
        expect_at(1, "read_last", 1, 1, 8'd0, 8'h01, 7'h01, 0);
        step(1);
        expect_at(1, "underflow1", 1, 1, 8'd0, 8'h01, 7'h01, 1);
        expect_at(2, "underflow2", 1, 1, 8'd0, 8'h01, 7'h01, 1);
        step(2);
        Rd_En = 1'b0;
        expect_at(1, "underflow_end", 1, 1, 8'd0, 8'h01, 7'h01, 0);
        step(1);

        // Write pointer to 128, drain to 128; check the almost-empty boundary.
        In_Wr_Gray = 8'hC0;
        expect_at(3, "fill_127", 0, 0, 8'd127, 8'h01, 7'h01, 0);
        step(3);
        Rd_En = 1'b1;
        expect_at(122, "ae_above", 0, 0, 8'd5, 8'h46, 7'h7B, 0);
        expect_at(123, "ae_at", 0, 1, 8'd4, 8'h42, 7'h7C, 0);
        expect_at(127, "drain_128", 1, 1, 8'd0, 8'hC0, 7'h00, 0);
        step(127);
        Rd_En = 1'b0;

        // Write pointer to 255, drain to 255.
        In_Wr_Gray = 8'h80;
        expect_at(3, "fill_255", 0, 0, 8'd127, 8'hC0, 7'h00, 0);
        step(3);
        Rd_En = 1'b1;
        expect_at(127, "at_255", 1, 1, 8'd0, 8'h80, 7'h7F, 0);
        step(127);
        Rd_En = 1'b0;

        // Write pointer wraps to 0: one word across the wrap.
        In_Wr_Gray = 8'h00;
        expect_at(3, "wrap_count", 0, 1, 8'd1, 8'h80, 7'h7F, 0);
        step(3);
        Rd_En = 1'b1;
        expect_at(1, "wrap_read", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        step(1);
        Rd_En = 1'b0;

        // Fill level 5 from read pointer 0, one read crosses the threshold.
        In_Wr_Gray = 8'h07;
        expect_at(3, "fill_5", 0, 0, 8'd5, 8'h00, 7'h00, 0);
        step(3);
        Rd_En = 1'b1;
        expect_at(1, "read_to_4", 0, 1, 8'd4, 8'h01, 7'h01, 0);
        step(1);
        Rd_En = 1'b0;

        // Refill to 5 then reset asynchronously between edges.
        In_Wr_Gray = 8'h05;
        expect_at(3, "refill_5", 0, 0, 8'd5, 8'h01, 7'h01, 0);
        step(4);
        Rst_N = 1'b0;
        expect_at(0, "async_rst", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(1, "rst_held", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        step(1);
        Rst_N = 1'b1;
        expect_at(1, "post_rst1", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(2, "post_rst2", 1, 1, 8'd0, 8'h00, 7'h00, 0);
        expect_at(3, "post_rst_fall", 0, 0, 8'd6, 8'h00, 7'h00, 0);
        step(3);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
